// File: rtl/nes_multi_poller.sv
// nes_multi_poller: polls 1-4 NES/SNES pads in parallel; define NES_EDGE_DETECT_EN to add the newly-pressed output
module nes_multi_poller #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 8,
  parameter int CLK_DIV  = 150
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CHANNELS-1:0]      nes_data,
  output logic                     nes_latch,
  output logic                     nes_clk,
  output logic [CHANNELS*BITS-1:0] buttons,
  output logic                     valid,
  output logic                     busy
`ifdef NES_EDGE_DETECT_EN
  ,
  output logic [CHANNELS*BITS-1:0] pressed
`endif
);
  localparam int CW = $clog2(2*CLK_DIV);
  localparam int BW = $clog2(BITS);
  typedef enum logic [2:0] {IDLE, LATCH, CLO, CHI, TAIL, DONE} state_t;
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [BW-1:0]            r_bit;
  logic [CHANNELS*BITS-1:0] r_shift;
  logic [CHANNELS-1:0]      r_s1, r_s2;
  logic [CHANNELS*BITS-1:0] w_sampled;
  logic                     w_last;
  assign w_last = (r_cnt == '0);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_c
    for (genvar k = 0; k < BITS; k++) begin : g_k
      assign w_sampled[c*BITS+k] = (r_bit == BW'(k)) ? ~r_s2[c] : r_shift[c*BITS+k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef NES_EDGE_DETECT_EN
      pressed   <= '0;
`endif
    end else begin
      r_s1  <= nes_data;
      r_s2  <= r_s1;
      r_cnt <= r_cnt - 1'b1;
      valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state   <= LATCH;
          nes_latch <= 1'b1;
          busy      <= 1'b1;
          r_bit     <= '0;
          r_cnt     <= CW'(2*CLK_DIV-1);
        end
        LATCH: if (w_last) begin
          r_state   <= CLO;
          nes_latch <= 1'b0;
          r_shift   <= w_sampled;
          r_bit     <= BW'(1);
          r_cnt     <= CW'(CLK_DIV-1);
        end
        CLO: if (w_last) begin
          r_state <= CHI;
          nes_clk <= 1'b1;
          r_cnt   <= CW'(CLK_DIV-1);
        end
        CHI: if (w_last) begin
          r_state <= (r_bit == BW'(BITS-1)) ? TAIL : CLO;
          nes_clk <= 1'b0;
          r_shift <= w_sampled;
          r_bit   <= r_bit + 1'b1;
          r_cnt   <= CW'(CLK_DIV-1);
        end
        TAIL: if (w_last) begin
          r_state <= DONE;
          buttons <= r_shift;
          valid   <= 1'b1;
`ifdef NES_EDGE_DETECT_EN
          pressed <= r_shift & ~buttons;
`endif
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nes_multi_poller.sv
// tb_nes_multi_poller: directed checks of an NES (2x8) and an SNES (1x16) poller against pad models
module tb_nes_multi_poller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  pa0 = '0, pa1 = '0;
  logic [15:0] pb = '0;
  int ia = 0, ib = 0;
  logic pca = 1'b0, pcb = 1'b0;
  logic a_latch, a_clk, a_valid, a_busy, b_latch, b_clk, b_valid, b_busy;
  logic [15:0] a_btn, b_btn, a_prs, b_prs;
  logic [1:0] a_data;
  logic [0:0] b_data;
  assign a_data = {~pa1[ia[2:0]], ~pa0[ia[2:0]]};
  assign b_data = ~pb[ib[3:0]];
  always @(posedge clk) begin
    pca <= a_clk;
    pcb <= b_clk;
    if (a_latch) ia <= 0; else if (a_clk && !pca && ia < 7) ia <= ia + 1;
    if (b_latch) ib <= 0; else if (b_clk && !pcb && ib < 15) ib <= ib + 1;
  end
  nes_multi_poller #(.CHANNELS(2), .BITS(8), .CLK_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .nes_data(a_data),
    .nes_latch(a_latch), .nes_clk(a_clk), .buttons(a_btn), .valid(a_valid), .busy(a_busy)
`ifdef NES_EDGE_DETECT_EN
    , .pressed(a_prs)
`endif
  );
  nes_multi_poller #(.CHANNELS(1), .BITS(16), .CLK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .nes_data(b_data),
    .nes_latch(b_latch), .nes_clk(b_clk), .buttons(b_btn), .valid(b_valid), .busy(b_busy)
`ifdef NES_EDGE_DETECT_EN
    , .pressed(b_prs)
`endif
  );
`ifndef NES_EDGE_DETECT_EN
  assign a_prs = '0;
  assign b_prs = '0;
`endif
  logic m_latch, m_clk, m_valid, m_busy;
  logic [15:0] m_btn;
  assign m_latch = sel ? b_latch : a_latch;
  assign m_clk   = sel ? b_clk   : a_clk;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_btn   = sel ? b_btn   : a_btn;
  int n_chk = 0, n_pass = 0;
  int vcyc, v2, nval, npul, nlat, bend;
  logic [15:0] bcap;
  logic [7:0] acc;
  logic [15:0] accb;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic poll(input int p2);
    logic pc;
    vcyc = -1; v2 = -1; nval = 0; npul = 0; nlat = 0; bend = -1; pc = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (vcyc < 0 && m_clk && !pc) npul++;
      if (vcyc < 0 && m_latch) nlat++;
      pc = m_clk;
      if (m_valid) begin
        nval++;
        if (vcyc < 0) begin vcyc = n; bcap = m_btn; end else v2 = n;
      end
      if (vcyc > 0 && n > vcyc && !m_busy && bend < 0) bend = n;
      start = (p2 < 0) || (n == p2);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    acc = '0; accb = '0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      acc  |= {a_latch, a_clk, a_busy, a_valid, b_latch, b_clk, b_busy, b_valid};
      accb |= a_btn | b_btn;
    end
    chk("idle_ctrl", acc, 0);
    chk("idle_buttons", accb, 0);
    sel = 1'b0; pa0 = 8'h01; pa1 = 8'h80;
    poll(0);
    chk("nes_valid_cycle", vcyc, 69);
    chk("nes_buttons", bcap, 16'h8001);
    chk("nes_clk_pulses", npul, 7);
    chk("nes_latch_cycles", nlat, 8);
    chk("nes_valid_count", nval, 1);
    chk("nes_busy_low", bend, 70);
    chk("nes_buttons_hold", m_btn, 16'h8001);
    sel = 1'b1; pb = 16'hA5C3;
    poll(0);
    chk("snes_valid_cycle", vcyc, 133);
    chk("snes_buttons", bcap, 16'hA5C3);
    chk("snes_clk_pulses", npul, 15);
    chk("snes_latch_cycles", nlat, 8);
    chk("snes_busy_low", bend, 134);
    sel = 1'b0; pa0 = 8'h5A; pa1 = 8'h0F;
    poll(20);
    chk("busy_valid_count", nval, 1);
    chk("busy_valid_cycle", vcyc, 69);
    chk("busy_buttons", bcap, 16'h0F5A);
    pa0 = 8'h11; pa1 = 8'h00;
    poll(-1);
    chk("b2b_valid_count", nval, 2);
    chk("b2b_first_valid", vcyc, 69);
    chk("b2b_second_valid", v2, 139);
    repeat (150) @(posedge clk);
    #1;
    pa0 = 8'hFF; pa1 = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    chk("rst_pre_clk_high", a_clk, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl_clear", {a_latch, a_clk, a_busy, a_valid}, 0);
    chk("rst_buttons_clear", a_btn, 0);
    #2 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("rst_buttons_stay", a_btn, 0);
    poll(0);
    chk("rst_repoll_cycle", vcyc, 69);
    chk("rst_repoll_buttons", bcap, 16'hFFFF);
`ifdef NES_EDGE_DETECT_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pa0 = 8'h03; pa1 = 8'h00;
    poll(0);
    chk("edge_pressed_1", a_prs, 16'h0003);
    pa0 = 8'h06;
    poll(0);
    chk("edge_pressed_2", a_prs, 16'h0004);
    chk("edge_buttons_2", a_btn, 16'h0006);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nes_multi_poller.md
# nes_multi_poller

Parametrised serial game-controller receiver that replaces the tied-off NES latch/clock path in the top level. On each poll request (driven by `frame_end`), it generates the NES latch and clock waveform and shifts in `BITS` buttons from each of `CHANNELS` controllers in parallel. It then publishes an active-high button vector with a one-cycle `valid` strobe to the input controller and player logic. One instance serves 1–4 NES (8-bit) or SNES (16-bit) pads.

## Interface
Parameters:
- `CHANNELS`, default 2: number of controller data inputs, legal range 1–4.
- `BITS`, default 8: bits per controller. Legal values are 8 (NES) and 16 (SNES).
- `CLK_DIV`, default 150: system clock cycles per half NES-clock period. Minimum 4.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. It is asynchronous and active-low.
- `start`, input, 1: poll request, sampled high on a `clk` edge. Ignored while `busy`.
- `nes_data`, input, `CHANNELS`: serial data, one line per controller. Active-low, meaning 0 = pressed.
- `nes_latch`, output, 1: latch pulse, shared by all controllers.
- `nes_clk`, output, 1: shift clock, shared by all controllers.
- `buttons`, output, `CHANNELS*BITS`: last completed poll, where 1 = pressed. Bit `buttons[c*BITS+k]` is button k of channel c. For NES, k=0..7 is A, B, Select, Start, Up, Down, Left, Right.
- `valid`, output, 1: one-cycle strobe, asserted in the cycle `buttons` updates.
- `busy`, output, 1: high while a poll is in progress.

## Operation
- All outputs are registered. Every `nes_data` bit passes through a 2-flop synchroniser before use.
- A single down-counter of width `$clog2(2*CLK_DIV)` times every phase. A bit counter of width `$clog2(BITS)` counts clock pulses. A shift register of width `CHANNELS*BITS` collects inverted samples.
- FSM states are IDLE, LATCH, CLO, CHI, TAIL, DONE:
  - IDLE: `nes_latch`=0, `nes_clk`=0, `busy`=0. When `start`=1, go to LATCH.
  - LATCH: `nes_latch`=1 for 2·`CLK_DIV` cycles. On its last cycle, sample bit 0 of every channel. Then go to CLO with k=1.
  - CLO: `nes_clk`=0 for `CLK_DIV` cycles, then go to CHI.
  - CHI: `nes_clk`=1 for `CLK_DIV` cycles. On its last cycle, sample bit k. If k=`BITS`-1, go to TAIL; otherwise increment k and go to CLO.
  - TAIL: `nes_clk`=0 for `CLK_DIV` cycles, then go to DONE.
  - DONE: copy the shift register to `buttons`, pulse `valid`=1, then go to IDLE.
- Each sample is stored as the inverted synchronised `nes_data[c]`, into slot `c*BITS+k`.
- `buttons` holds its value between polls. It changes only in DONE.
- A floating or unplugged pad, pulled high, reads as all zeros (no buttons pressed).

## Timing
- Cycle 0 is the edge on which `start` is sampled high in IDLE.
- `busy` and `nes_latch` are high from cycle 1.
- `nes_latch` falls at cycle 1+2·`CLK_DIV`.
- Pulse k of `nes_clk` is high during cycles 1+2k·`CLK_DIV`+`CLK_DIV` through 1+2(k+1)·`CLK_DIV`−1.
- `valid` is high and `buttons` updates in cycle T = 1+(2·`BITS`+1)·`CLK_DIV`. `busy` is low from T+1.
- With `BITS`=8 and `CLK_DIV`=4, T=69.
- `start` must stay low for one cycle after T before a new poll is accepted. Back-to-back `start` held high re-polls from cycle T+1.
- `start` during `busy` is dropped, not queued.
- Asserting reset at any point, including mid-poll, immediately clears all of the following and returns the FSM to IDLE: `buttons`=0, `valid`=0, `busy`=0, `nes_latch`=0, `nes_clk`=0, counters, and synchronisers. A partial poll is discarded.
- Input-to-sample latency is 2 `clk` cycles, from the synchroniser. `CLK_DIV`≥4 guarantees the sampled value reflects the level set by the preceding `nes_clk` rising edge.

## Configuration
- Macro `NES_EDGE_DETECT_EN`.
- Defined:
  - Adds output port `pressed`, width `CHANNELS*BITS`.
  - In DONE, `pressed` = new `buttons` & ~old `buttons`, updated in the same cycle as `buttons`.
  - `pressed` holds until the next DONE. Reset value is 0.
- Undefined: the port, its register, and the previous-value logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: with no `start`, `nes_latch`=`nes_clk`=`busy`=`valid`=0 and `buttons`=0 over 1000 cycles.
- Single NES poll, `CHANNELS`=2, `BITS`=8, `CLK_DIV`=4:
  - Stimulus: pad models return 8'b0000_0001 pressed on channel 0 (A) and 8'b1000_0000 pressed on channel 1 (Right).
  - Required: `valid` at cycle 69, `buttons`=16'h8001, exactly 7 `nes_clk` pulses, and `nes_latch` high for 8 cycles.
- SNES mode, `BITS`=16, `CLK_DIV`=4: pad returns 16'hA5C3 pressed. Required: `buttons`=16'hA5C3 at cycle 133, with 15 clock pulses.
- Busy behaviour: pulse `start` at cycles 0 and 20. Required: exactly one `valid`, at cycle 69, and no second poll starts.
- Reset at cycle 30 mid-poll. Required: `nes_latch` and `nes_clk` low and `busy`=0 immediately, and `buttons` remain 0. A subsequent poll completes normally 69 cycles after its `start`.
- With `NES_EDGE_DETECT_EN`: poll 1 reads 8'h03, poll 2 reads 8'h06. Required: `pressed`=8'h03 after poll 1 and `pressed`=8'h04 after poll 2.
